mlp_stream_sequencer: RTL and testbench

Parametrised load/drain sequencer for the MLP accelerator. It replaces host-driven row, layer and beat indices with internal counters behind a valid/ready stream. Incoming beats are assembled into full activation rows (written to the activation buffer) and full weight rows (handed to the compute array). After the compute array signals completion, the block drains the result matrix as a backpressured beat stream.

---
 rtl/mlp_stream_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_mlp_stream_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_stream_sequencer.sv
// mlp_stream_sequencer: assembles activation and weight rows from a beat
// stream using internal row/beat/layer counters, hands weight rows to the
// compute array, then drains the result matrix as a backpressured stream.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_i
// LOAD0    | layer 0: per row, BPR activation beats then BPR weight beats
// LOADW    | layers 1..L-1: BPR weight beats per row
// WAIT_CMP | load finished, waiting for cmp_done_i
// DRAIN    | reading result rows and emitting them as beats
module mlp_stream_sequencer #(
  parameter int N      = 16,
  parameter int DW     = 16,
  parameter int LANES  = 2,
  parameter int LAYERS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic [$clog2(LAYERS+1)-1:0]    cfg_layers_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic                           in_type_i,
  input  logic [LANES*DW-1:0]            in_payload_i,
  output logic                           act_we_o,
  output logic [$clog2(N)-1:0]           act_row_o,
  output logic [N*DW-1:0]                act_data_o,
  output logic                           w_valid_o,
  input  logic                           w_ready_i,
  output logic [N*DW-1:0]                w_row_o,
  output logic [$clog2(N)-1:0]           w_idx_o,
  output logic [$clog2(LAYERS)-1:0]      w_layer_o,
  input  logic                           cmp_done_i,
  output logic                           res_rd_en_o,
  output logic [$clog2(N)-1:0]           res_rd_row_o,
  input  logic [N*DW-1:0]                res_rd_data_i,
  output logic                           res_valid_o,
  input  logic                           res_ready_i,
  output logic [LANES*DW-1:0]            res_payload_o,
  output logic                           res_last_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int BPR    = N / LANES;
  localparam int BEAT_W = LANES * DW;
  localparam int BW     = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int RW     = $clog2(N);
  localparam int LW     = $clog2(LAYERS);
  localparam int CW     = $clog2(LAYERS + 1);

  localparam logic [BW-1:0] BEAT_LAST = BW'(BPR - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD0,
    S_LOADW,
    S_WAIT_CMP,
    S_DRAIN
  } state_t;

  state_t          state;
  logic [BW-1:0]   beat_cnt;
  logic [RW-1:0]   row_cnt;
  logic [LW-1:0]   layer_cnt;
  logic [CW-1:0]   layers_left;
  logic            phase_act;
  logic            load_done;
  logic [N*DW-1:0] asm_q;
  logic [N*DW-1:0] asm_next;
  logic [N*DW-1:0] drain_buf;
  logic            rd_pend;
  logic [RW-1:0]   drain_row;
  logic [BW-1:0]   drain_beat;
  logic [BW-1:0]   drain_beat_nx;
  logic [BEAT_W-1:0] drain_slice_nx;
  logic [CW-1:0]   cfg_clamped;

  logic in_load, accept, exp_type, type_ok, w_hs, res_hs, final_layer;

  assign in_load     = (state == S_LOAD0) || (state == S_LOADW);
  assign in_ready_o  = in_load && !load_done && !(w_valid_o && !w_ready_i);
  assign busy_o      = (state != S_IDLE);
  assign accept      = in_valid_i && in_ready_o;
  assign exp_type    = (state == S_LOAD0) && phase_act;
  assign type_ok     = (in_type_i == exp_type);
  assign w_hs        = w_valid_o && w_ready_i;
  assign res_hs      = res_valid_o && res_ready_i;
  // layers_left counts down to zero on the final layer
  assign final_layer = (layers_left == '0);

  // Row assembly buffer with the current beat merged in at its lane slot
  always_comb begin
    asm_next = asm_q;
    asm_next[int'(beat_cnt)*BEAT_W +: BEAT_W] = in_payload_i;
  end

  // Clamp requested layer count into 1..LAYERS
  always_comb begin
    cfg_clamped = cfg_layers_i;
    if (cfg_layers_i == '0)
      cfg_clamped = CW'(1);
    else if (cfg_layers_i > CW'(LAYERS))
      cfg_clamped = CW'(LAYERS);
  end

  // Next result beat slice out of the captured row
  always_comb begin
    drain_beat_nx  = drain_beat + 1'b1;
    drain_slice_nx = drain_buf[int'(drain_beat_nx)*BEAT_W +: BEAT_W];
  end

  // Sequencer FSM with all counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      beat_cnt      <= '0;
      row_cnt       <= '0;
      layer_cnt     <= '0;
      layers_left   <= '0;
      phase_act     <= 1'b0;
      load_done     <= 1'b0;
      asm_q         <= '0;
      drain_buf     <= '0;
      rd_pend       <= 1'b0;
      drain_row     <= '0;
      drain_beat    <= '0;
      act_we_o      <= 1'b0;
      act_row_o     <= '0;
      act_data_o    <= '0;
      w_valid_o     <= 1'b0;
      w_row_o       <= '0;
      w_idx_o       <= '0;
      w_layer_o     <= '0;
      res_rd_en_o   <= 1'b0;
      res_rd_row_o  <= '0;
      res_valid_o   <= 1'b0;
      res_payload_o <= '0;
      res_last_o    <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      act_we_o    <= 1'b0;
      res_rd_en_o <= 1'b0;
      rd_pend     <= res_rd_en_o;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            err_o       <= 1'b0;
            layers_left <= cfg_clamped - 1'b1;
            beat_cnt    <= '0;
            row_cnt     <= '0;
            layer_cnt   <= '0;
            phase_act   <= 1'b1;
            load_done   <= 1'b0;
            state       <= S_LOAD0;
          end
        end
        S_LOAD0, S_LOADW: begin
          if (w_hs) w_valid_o <= 1'b0;
          // load_done blocks further beats, so the handoff is the last event
          if (w_hs && load_done) begin
            load_done <= 1'b0;
            state     <= S_WAIT_CMP;
          end
          if (accept) begin
            if (!type_ok) begin
              err_o <= 1'b1;
            end else begin
              asm_q <= asm_next;
              if (beat_cnt != BEAT_LAST) begin
                beat_cnt <= beat_cnt + 1'b1;
              end else begin
                beat_cnt <= '0;
                if (exp_type) begin
                  act_we_o   <= 1'b1;
                  act_row_o  <= row_cnt;
                  act_data_o <= asm_next;
                  phase_act  <= 1'b0;
                end else begin
                  w_valid_o <= 1'b1;
                  w_row_o   <= asm_next;
                  w_idx_o   <= row_cnt;
                  w_layer_o <= layer_cnt;
                  if (row_cnt != ROW_LAST) begin
                    row_cnt   <= row_cnt + 1'b1;
                    phase_act <= (state == S_LOAD0);
                  end else begin
                    row_cnt   <= '0;
                    phase_act <= 1'b0;
                    if (final_layer) begin
                      load_done <= 1'b1;
                    end else begin
                      layer_cnt   <= layer_cnt + 1'b1;
                      layers_left <= layers_left - 1'b1;
                      state       <= S_LOADW;
                    end
                  end
                end
              end
            end
          end
        end
        S_WAIT_CMP: begin
          if (cmp_done_i) begin
            drain_row    <= '0;
            drain_beat   <= '0;
            res_rd_en_o  <= 1'b1;
            res_rd_row_o <= '0;
            state        <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rd_pend) begin
            drain_buf     <= res_rd_data_i;
            drain_beat    <= '0;
            res_valid_o   <= 1'b1;
            res_payload_o <= res_rd_data_i[BEAT_W-1:0];
            res_last_o    <= (drain_row == ROW_LAST) && (BPR == 1);
          end else if (res_hs) begin
            if (drain_beat != BEAT_LAST) begin
              drain_beat    <= drain_beat_nx;
              res_payload_o <= drain_slice_nx;
              res_last_o    <= (drain_row == ROW_LAST) && (drain_beat_nx == BEAT_LAST);
            end else begin
              res_valid_o <= 1'b0;
              res_last_o  <= 1'b0;
              drain_beat  <= '0;
              if (drain_row == ROW_LAST) begin
                state <= S_IDLE;
              end else begin
                drain_row    <= drain_row + 1'b1;
                res_rd_en_o  <= 1'b1;
                res_rd_row_o <= drain_row + 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_stream_sequencer.sv
// tb_mlp_stream_sequencer: table-driven first rows of a job plus directed
// sequences for the full load, drain, single-layer and mid-drain reset cases.
module tb_mlp_stream_sequencer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [3:0]    cfg_layers_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          in_type_i;
  logic [31:0]   in_payload_i;
  logic          act_we_o;
  logic [3:0]    act_row_o;
  logic [255:0]  act_data_o;
  logic          w_valid_o;
  logic          w_ready_i;
  logic [255:0]  w_row_o;
  logic [3:0]    w_idx_o;
  logic [2:0]    w_layer_o;
  logic          cmp_done_i;
  logic          res_rd_en_o;
  logic [3:0]    res_rd_row_o;
  logic [255:0]  res_rd_data_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [31:0]   res_payload_o;
  logic          res_last_o;
  logic          busy_o;
  logic          err_o;

  int n_vec = 0;
  int n_err = 0;
  int mon_act = 0;
  int mon_w = 0;

  mlp_stream_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cfg_layers_i(cfg_layers_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_type_i(in_type_i),
    .in_payload_i(in_payload_i), .act_we_o(act_we_o), .act_row_o(act_row_o),
    .act_data_o(act_data_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .w_row_o(w_row_o), .w_idx_o(w_idx_o), .w_layer_o(w_layer_o),
    .cmp_done_i(cmp_done_i), .res_rd_en_o(res_rd_en_o), .res_rd_row_o(res_rd_row_o),
    .res_rd_data_i(res_rd_data_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_payload_o(res_payload_o), .res_last_o(res_last_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Result array model: element (row, col) = row*16 + col, one-cycle read
  always @(posedge clk) begin
    if (res_rd_en_o)
      for (int c = 0; c < 16; c++)
        res_rd_data_i[c*16 +: 16] <= 16'(int'(res_rd_row_o) * 16 + c);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_pat(input int b, input int k);
    return {16'(b + 2*k + 1), 16'(b + 2*k)};
  endfunction

  function automatic logic [255:0] row_pat(input int b);
    logic [255:0] r;
    for (int c = 0; c < 16; c++) r[c*16 +: 16] = 16'(b + c);
    return r;
  endfunction

  // Row / handoff ordering monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (act_we_o) begin
        chk("mon_act_row", 256'(act_row_o), 256'(mon_act % 16));
        mon_act++;
      end
      if (w_valid_o && w_ready_i) begin
        chk("mon_w_idx", 256'(w_idx_o), 256'(mon_w % 16));
        chk("mon_w_layer", 256'(w_layer_o), 256'(mon_w / 16));
        mon_w++;
      end
    end
  end

  typedef struct {
    logic        start;
    logic [3:0]  cfg;
    logic        v;
    logic        t;
    logic [31:0] pay;
    logic        wr;
    logic        e_rdy;
    logic        e_we;
    logic        e_wv;
    logic        e_err;
    logic        act_chk;
    int          act_base;
    logic [3:0]  act_row;
    logic        w_chk;
    int          w_base;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic [3:0] cfg, input logic v, input logic t,
                     input logic [31:0] p, input logic wr, input logic rdy, input logic we,
                     input logic wv, input logic er, input logic ac, input int ab,
                     input logic [3:0] ar, input logic wc, input int wb);
    vec_t x;
    x.start = s; x.cfg = cfg; x.v = v; x.t = t; x.pay = p; x.wr = wr;
    x.e_rdy = rdy; x.e_we = we; x.e_wv = wv; x.e_err = er;
    x.act_chk = ac; x.act_base = ab; x.act_row = ar; x.w_chk = wc; x.w_base = wb;
    tbl.push_back(x);
  endtask

  task automatic send_beat(input logic t, input logic [31:0] p);
    int n;
    n = 0;
    in_valid_i = 1'b1; in_type_i = t; in_payload_i = p;
    @(negedge clk);
    while (!in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_rdy", 256'(in_ready_o), 256'(1));
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  logic [31:0] exp_pay;
  logic [31:0] prev_pay;
  logic        prev_valid, prev_ready;
  int          beats, cyc, last_rd_cyc, n;

  initial begin
    // first rows of an 8-layer job, one record per cycle
    add(1, 8, 0, 0, 32'h0, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0);
    for (int k = 0; k < 8; k++)
      add(0, 0, 1, 1, beat_pat(1, k), 1,  1, 0, 0, 0,  0, 0, 0,  0, 0);
    for (int k = 0; k < 8; k++)
      add(0, 0, 1, 0, beat_pat(16'h1000, k), 1,  1, (k == 0), 0, 0,  (k == 0), 1, 0,  0, 0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 1, 1, beat_pat(100, 0), 0,  0, 0, 1, 0,  0, 0, 0,  1, 16'h1000);
    add(0, 0, 1, 1, beat_pat(100, 0), 1,  1, 0, 1, 0,  0, 0, 0,  1, 16'h1000);
    add(0, 0, 1, 1, beat_pat(100, 1), 1,  1, 0, 0, 0,  0, 0, 0,  0, 0);
    add(0, 0, 1, 0, 32'hdead_beef, 1,     1, 0, 0, 0,  0, 0, 0,  0, 0);
    for (int k = 2; k < 8; k++)
      add(0, 0, 1, 1, beat_pat(100, k), 1,  1, 0, 0, 1,  0, 0, 0,  0, 0);
    add(0, 0, 0, 0, 32'h0, 1,  1, 1, 0, 1,  1, 100, 1,  0, 0);
    add(0, 0, 0, 0, 32'h0, 1,  1, 0, 0, 1,  0, 0, 0,  0, 0);

    rst_n = 1'b0; start_i = 1'b0; cfg_layers_i = '0; in_valid_i = 1'b0; in_type_i = 1'b0;
    in_payload_i = '0; w_ready_i = 1'b1; cmp_done_i = 1'b0; res_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ctrl", 256'({in_ready_o, act_we_o, w_valid_o, res_rd_en_o, res_valid_o,
                            res_last_o, busy_o, err_o}), 256'(0));
    chk("reset_data", 256'(|{act_row_o, act_data_o, w_row_o, w_idx_o, w_layer_o,
                             res_rd_row_o, res_payload_o}), 256'(0));

    // cmp_done_i in IDLE must not start anything
    @(posedge clk); #1 cmp_done_i = 1'b1;
    @(posedge clk); #1 cmp_done_i = 1'b0;
    @(negedge clk);
    chk("cmp_done_idle", 256'({busy_o, res_rd_en_o}), 256'(0));

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      start_i = tbl[i].start; cfg_layers_i = tbl[i].cfg; in_valid_i = tbl[i].v;
      in_type_i = tbl[i].t; in_payload_i = tbl[i].pay; w_ready_i = tbl[i].wr;
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy_we_wv_err", i), 256'({in_ready_o, act_we_o, w_valid_o, err_o}),
          256'({tbl[i].e_rdy, tbl[i].e_we, tbl[i].e_wv, tbl[i].e_err}));
      if (tbl[i].act_chk) begin
        chk($sformatf("tbl%0d_act_data", i), act_data_o, row_pat(tbl[i].act_base));
        chk($sformatf("tbl%0d_act_row", i), 256'(act_row_o), 256'(tbl[i].act_row));
      end
      if (tbl[i].w_chk)
        chk($sformatf("tbl%0d_w_row", i), w_row_o, row_pat(tbl[i].w_base));
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0; w_ready_i = 1'b1;

    // remainder of the 8-layer load
    for (int k = 0; k < 8; k++) send_beat(1'b0, beat_pat(16'h2000, k));
    for (int r = 2; r < 16; r++) begin
      for (int k = 0; k < 8; k++) send_beat(1'b1, beat_pat(r * 16, k));
      for (int k = 0; k < 8; k++) send_beat(1'b0, beat_pat(16'h3000 + r * 16, k));
    end
    for (int l = 1; l < 8; l++)
      for (int r = 0; r < 16; r++)
        for (int k = 0; k < 8; k++) send_beat(1'b0, beat_pat(l * 256 + r * 16, k));
    repeat (3) @(negedge clk);
    chk("a_act_pulses", 256'(mon_act), 256'(16));
    chk("a_w_rows", 256'(mon_w), 256'(128));
    chk("a_wait_cmp", 256'({busy_o, in_ready_o, w_valid_o}), 256'({1'b1, 1'b0, 1'b0}));
    chk("a_last_layer", 256'({w_layer_o, w_idx_o}), 256'({3'd7, 4'd15}));

    // start_i outside IDLE is ignored: err_o stays set, still not loading
    @(posedge clk); #1 start_i = 1'b1; cfg_layers_i = 4'd8;
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    chk("start_ignored", 256'({err_o, in_ready_o, busy_o}), 256'({1'b1, 1'b0, 1'b1}));

    // drain with toggling res_ready_i
    @(posedge clk); #1 cmp_done_i = 1'b1;
    @(posedge clk); #1 cmp_done_i = 1'b0;
    beats = 0; cyc = 0; last_rd_cyc = -100; prev_valid = 1'b0; prev_ready = 1'b0; prev_pay = '0;
    while (beats < 128 && cyc < 3000) begin
      res_ready_i = (cyc % 2 == 0);
      @(negedge clk);
      if (res_rd_en_o) last_rd_cyc = cyc;
      if (res_valid_o && !prev_valid)
        chk("rd_to_valid", 256'(cyc - last_rd_cyc), 256'(2));
      if (res_valid_o && prev_valid && !prev_ready)
        chk("res_hold", 256'(res_payload_o), 256'(prev_pay));
      if (res_valid_o && res_ready_i) begin
        exp_pay = beat_pat((beats / 8) * 16, beats % 8);
        chk($sformatf("res_beat%0d", beats), 256'(res_payload_o), 256'(exp_pay));
        chk($sformatf("res_last%0d", beats), 256'(res_last_o), 256'(beats == 127));
        beats++;
      end
      prev_valid = res_valid_o; prev_ready = res_ready_i; prev_pay = res_payload_o;
      @(posedge clk); #1;
      cyc++;
    end
    res_ready_i = 1'b0;
    chk("drain_beats", 256'(beats), 256'(128));
    @(negedge clk);
    chk("drain_idle", 256'({busy_o, res_valid_o}), 256'(0));

    // single-layer job via cfg_layers_i = 0; start clears err_o
    mon_act = 0; mon_w = 0;
    @(posedge clk); #1 start_i = 1'b1; cfg_layers_i = 4'd0;
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    chk("b_err_cleared", 256'({err_o, busy_o}), 256'({1'b0, 1'b1}));
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 8; k++) send_beat(1'b1, beat_pat(r * 16, k));
      for (int k = 0; k < 8; k++) send_beat(1'b0, beat_pat(16'h4000 + r * 16, k));
    end
    repeat (3) @(negedge clk);
    chk("b_act_pulses", 256'(mon_act), 256'(16));
    chk("b_w_rows", 256'(mon_w), 256'(16));
    chk("b_wait_cmp", 256'({busy_o, in_ready_o}), 256'({1'b1, 1'b0}));
    chk("b_layer", 256'({w_layer_o, w_idx_o}), 256'({3'd0, 4'd15}));

    // reset for one cycle mid-DRAIN with a result beat pending
    @(posedge clk); #1 cmp_done_i = 1'b1;
    @(posedge clk); #1 cmp_done_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (!res_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b_res_valid_seen", 256'(res_valid_o), 256'(1));
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ctrl", 256'({in_ready_o, act_we_o, w_valid_o, res_rd_en_o, res_valid_o,
                            res_last_o, busy_o, err_o}), 256'(0));
    chk("abort_data", 256'(|{act_row_o, act_data_o, w_row_o, w_idx_o, w_layer_o,
                             res_rd_row_o, res_payload_o}), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
